// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle CPU control FSM: sequences IF/ID/EXE/MEM/WB and drives datapath enables and selects.
// Latency: 2 (jump/NOP), 3 (branch), 4 (ALU, sw) or 5 (lw) cycles per instruction; outputs are combinational from state.
// No backpressure; halt parks in ID until reset. Define MC_EXT_BRANCH_EN to decode bne/bltz.
module multi_cycle_ctrl #(
    parameter int OPW = 6
) (
    input  logic           CLK,
    input  logic           nReset,
    input  logic [OPW-1:0] Op_code,
    input  logic           Zero,
    input  logic           Sign,
    output logic           PCWre,
    output logic           IRWre,
    output logic           RegWre,
    output logic           nRD,
    output logic           nWR,
    output logic           ALUSrcA,
    output logic           ALUSrcB,
    output logic           ExtSel,
    output logic           DBDataSrc,
    output logic           WrRegDSrc,
    output logic [1:0]     RegDst,
    output logic [1:0]     PCSrc,
    output logic [2:0]     ALUOp,
    output logic [2:0]     State
);
    localparam logic [OPW-1:0] OP_ADD   = OPW'(6'b000000);
    localparam logic [OPW-1:0] OP_SUB   = OPW'(6'b000001);
    localparam logic [OPW-1:0] OP_ADDIU = OPW'(6'b000010);
    localparam logic [OPW-1:0] OP_AND   = OPW'(6'b010000);
    localparam logic [OPW-1:0] OP_ANDI  = OPW'(6'b010001);
    localparam logic [OPW-1:0] OP_ORI   = OPW'(6'b010010);
    localparam logic [OPW-1:0] OP_XORI  = OPW'(6'b010011);
    localparam logic [OPW-1:0] OP_SLL   = OPW'(6'b011000);
    localparam logic [OPW-1:0] OP_SLTI  = OPW'(6'b100110);
    localparam logic [OPW-1:0] OP_SLT   = OPW'(6'b100111);
    localparam logic [OPW-1:0] OP_SW    = OPW'(6'b110000);
    localparam logic [OPW-1:0] OP_LW    = OPW'(6'b110001);
    localparam logic [OPW-1:0] OP_BEQ   = OPW'(6'b110100);
    localparam logic [OPW-1:0] OP_J     = OPW'(6'b111000);
    localparam logic [OPW-1:0] OP_JR    = OPW'(6'b111001);
    localparam logic [OPW-1:0] OP_JAL   = OPW'(6'b111010);
    localparam logic [OPW-1:0] OP_HALT  = OPW'(6'b111111);

    typedef enum logic [2:0] {
        S_IF    = 3'b000,
        S_ID    = 3'b001,
        S_EXE_M = 3'b010,
        S_MEM   = 3'b011,
        S_WB_L  = 3'b100,
        S_EXE_B = 3'b101,
        S_EXE_A = 3'b110,
        S_WB_A  = 3'b111
    } state_t;

    state_t     state;
    logic       run;
    logic       is_alu, is_br, is_lw, is_sw, is_j, is_jr, is_jal, is_halt;
    logic       br_taken;
    logic [2:0] alu_op;
    logic       src_a, src_b, ext_sel;
    logic [1:0] reg_dst;

    assign is_alu  = (Op_code == OP_ADD)  || (Op_code == OP_SUB)  || (Op_code == OP_ADDIU) ||
                     (Op_code == OP_AND)  || (Op_code == OP_ANDI) || (Op_code == OP_ORI)   ||
                     (Op_code == OP_XORI) || (Op_code == OP_SLL)  || (Op_code == OP_SLTI)  ||
                     (Op_code == OP_SLT);
    assign is_lw   = (Op_code == OP_LW);
    assign is_sw   = (Op_code == OP_SW);
    assign is_j    = (Op_code == OP_J);
    assign is_jr   = (Op_code == OP_JR);
    assign is_jal  = (Op_code == OP_JAL);
    assign is_halt = (Op_code == OP_HALT);

`ifdef MC_EXT_BRANCH_EN
    localparam logic [OPW-1:0] OP_BNE  = OPW'(6'b110101);
    localparam logic [OPW-1:0] OP_BLTZ = OPW'(6'b110110);
    assign is_br    = (Op_code == OP_BEQ) || (Op_code == OP_BNE) || (Op_code == OP_BLTZ);
    assign br_taken = ((Op_code == OP_BEQ) && Zero) || ((Op_code == OP_BNE) && !Zero) ||
                      ((Op_code == OP_BLTZ) && Sign);
`else
    logic sign_unused;
    assign sign_unused = Sign;
    assign is_br       = (Op_code == OP_BEQ);
    assign br_taken    = Zero;
`endif

    // Datapath selects for the execute phase; held unchanged from EXE through WB.
    always_comb begin
        alu_op  = 3'b000;
        src_a   = 1'b0;
        src_b   = 1'b0;
        ext_sel = 1'b1;
        reg_dst = 2'b00;
        case (Op_code)
            OP_ADD:   reg_dst = 2'b10;
            OP_SUB:   begin alu_op = 3'b001; reg_dst = 2'b10; end
            OP_ADDIU: begin src_b = 1'b1; reg_dst = 2'b01; end
            OP_AND:   begin alu_op = 3'b100; reg_dst = 2'b10; end
            OP_ANDI:  begin alu_op = 3'b100; src_b = 1'b1; ext_sel = 1'b0; reg_dst = 2'b01; end
            OP_ORI:   begin alu_op = 3'b011; src_b = 1'b1; ext_sel = 1'b0; reg_dst = 2'b01; end
            OP_XORI:  begin alu_op = 3'b111; src_b = 1'b1; ext_sel = 1'b0; reg_dst = 2'b01; end
            OP_SLL:   begin alu_op = 3'b010; src_a = 1'b1; reg_dst = 2'b10; end
            OP_SLTI:  begin alu_op = 3'b110; src_b = 1'b1; reg_dst = 2'b01; end
            OP_SLT:   begin alu_op = 3'b110; reg_dst = 2'b10; end
            OP_SW:    src_b = 1'b1;
            OP_LW:    begin src_b = 1'b1; reg_dst = 2'b01; end
            default:  if (is_br) alu_op = 3'b001;
        endcase
    end

    // run holds the FSM in IF for the first edge after reset release.
    always_ff @(posedge CLK or negedge nReset) begin
        if (!nReset) begin
            state <= S_IF;
            run   <= 1'b0;
        end else if (!run) begin
            run <= 1'b1;
        end else begin
            case (state)
                S_IF:    state <= S_ID;
                S_ID: begin
                    if (is_alu)              state <= S_EXE_A;
                    else if (is_br)          state <= S_EXE_B;
                    else if (is_lw || is_sw) state <= S_EXE_M;
                    else if (is_halt)        state <= S_ID;
                    else                     state <= S_IF;
                end
                S_EXE_A: state <= S_WB_A;
                S_EXE_M: state <= S_MEM;
                S_MEM:   state <= is_lw ? S_WB_L : S_IF;
                default: state <= S_IF;
            endcase
        end
    end

    assign State = state;

    always_comb begin
        PCWre     = 1'b0;
        IRWre     = 1'b0;
        RegWre    = 1'b0;
        nRD       = 1'b1;
        nWR       = 1'b1;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 1'b0;
        ExtSel    = 1'b0;
        DBDataSrc = 1'b0;
        WrRegDSrc = 1'b0;
        RegDst    = 2'b00;
        PCSrc     = 2'b00;
        ALUOp     = 3'b000;
        if (run) begin
            case (state)
                S_IF: IRWre = 1'b1;
                S_ID: begin
                    // Jumps and undefined opcodes retire here; halt never does.
                    PCWre  = !(is_alu || is_br || is_lw || is_sw || is_halt);
                    RegWre = is_jal;
                    if (is_j || is_jal) PCSrc = 2'b11;
                    else if (is_jr)     PCSrc = 2'b10;
                end
                default: begin
                    ALUOp     = alu_op;
                    ALUSrcA   = src_a;
                    ALUSrcB   = src_b;
                    ExtSel    = ext_sel;
                    RegDst    = reg_dst;
                    DBDataSrc = is_lw;
                    WrRegDSrc = (state != S_EXE_B);
                    case (state)
                        S_WB_A, S_WB_L: begin PCWre = 1'b1; RegWre = 1'b1; end
                        S_EXE_B: begin
                            PCWre = 1'b1;
                            PCSrc = br_taken ? 2'b01 : 2'b00;
                        end
                        S_MEM: begin
                            PCWre = is_sw;
                            nRD   = !is_lw;
                            nWR   = !is_sw;
                        end
                        default: ;
                    endcase
                end
            endcase
        end
    end
endmodule
